// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs decoded instruction fields into RV32I words and streams them into instruction memory
// Optional NOP padding of the unused memory tail: define INSTR_ENCODER_NOP_PAD_EN
module instr_encoder_loader #(
  parameter int IMEM_DEPTH = 64,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_fmt,
  input  logic [2:0]        in_funct3,
  input  logic              in_f7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PAD  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [31:0]     NOP_C   = 32'h0000_0013;

  state_t          state;
  logic [31:0]     enc;
  logic            illegal;
  logic            accept;
  logic [ADDR_W:0] count_nxt;

  assign in_ready  = (state == LOAD) && (count < DEPTH_C);
  assign accept    = in_valid && in_ready;
  assign count_nxt = count + (ADDR_W+1)'(1);

  // Field packing per instruction class; unknown classes and misaligned branch/jump targets are flagged
  always_comb begin
    enc     = 32'h0;
    illegal = 1'b0;
    case (in_fmt)
      4'd0: enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
      4'd1: begin
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
          enc = {1'b0, in_f7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        else
          enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      end
      4'd2: enc = {in_imm[31:12], in_rd, 7'b0010111};
      4'd3: enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      4'd4: enc = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      4'd5: enc = {in_imm[31:12], in_rd, 7'b0110111};
      4'd6: begin
        enc     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], 7'b1100011};
        illegal = in_imm[0];
      end
      4'd7: enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
      4'd8: begin
        enc     = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        illegal = in_imm[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  // Load sequencer: registered write port, word counter and sticky status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
      count      <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      // A write earned this cycle is issued even if start restarts the load
      imem_we <= 1'b0;
      if (accept && !illegal) begin
        imem_we    <= 1'b1;
        imem_addr  <= count[ADDR_W-1:0];
        imem_wdata <= enc;
      end
`ifdef INSTR_ENCODER_NOP_PAD_EN
      else if (state == PAD && count < DEPTH_C) begin
        imem_we    <= 1'b1;
        imem_addr  <= count[ADDR_W-1:0];
        imem_wdata <= NOP_C;
      end
`endif

      if (start) begin
        state <= LOAD;
        count <= '0;
        done  <= 1'b0;
        error <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (accept) begin
              if (illegal) begin
                state <= ERR;
                error <= 1'b1;
              end else begin
                count <= count_nxt;
                if (count_nxt == DEPTH_C) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else if (in_last) begin
`ifdef INSTR_ENCODER_NOP_PAD_EN
                  state <= PAD;
`else
                  state <= DONE;
                  done  <= 1'b1;
`endif
                end
              end
            end
          end
`ifdef INSTR_ENCODER_NOP_PAD_EN
          PAD: begin
            if (count < DEPTH_C) begin
              count <= count_nxt;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
`endif
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - scoreboard bench for instr_encoder_loader
module tb_instr_encoder_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_fmt = '0;
  logic [2:0]    in_funct3 = '0;
  logic          in_f7b5 = 1'b0;
  logic [4:0]    in_rd = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [31:0]   in_imm = '0;
  logic          in_last = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;
  int exp_addr = 0;
  logic [AW+31:0] exp_q[$];

  instr_encoder_loader #(.IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_funct3(in_funct3), .in_f7b5(in_f7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // write monitor: every observed write must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h", imem_addr, imem_wdata);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          errors++;
          $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                   imem_addr, imem_wdata, e[AW+31:32], e[31:0]);
        end
      end
    end
  end

  task automatic do_start();
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    exp_addr = 0;
  endtask

  task automatic drive(input logic [3:0] fmt, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic last);
    in_fmt = fmt; in_funct3 = f3; in_f7b5 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    in_valid = 1'b1;
  endtask

  // drive a legal beat, push its expected write, return at the negedge after acceptance
  task automatic send(input logic [3:0] fmt, input logic [2:0] f3, input logic f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic last, input logic [31:0] exp);
    int k;
    drive(fmt, f3, f7, rd, rs1, rs2, imm, last);
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout in_ready=%b want 1", in_ready);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back({AW'(exp_addr), exp});
      exp_addr++;
      @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin @(negedge clk); k++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain pending=%0d want 0", name, exp_q.size());
    end
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 200) begin @(negedge clk); k++; end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done=%b want 1", name, done);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, count, done, error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs rdy=%b we=%b addr=%0d wdata=%h cnt=%0d done=%b err=%b want all 0",
               in_ready, imem_we, imem_addr, imem_wdata, count, done, error);
    end
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || imem_we !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_accept rdy=%b we=%b want 0 0", in_ready, imem_we);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_single();
    do_start();
    checks++;
    if (in_ready !== 1'b1 || count !== '0) begin
      errors++;
      $display("FAIL start_load rdy=%b cnt=%0d want 1 0", in_ready, count);
    end
    send(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0050_0093);
    in_valid = 1'b0;
    checks++;
    if (imem_we !== 1'b1 || count !== 7'd1) begin
      errors++;
      $display("FAIL single_n1 we=%b cnt=%0d want 1 1", imem_we, count);
    end
    wait_drain("single");
  endtask

  task automatic test_back_to_back();
    do_start();
    send(4'd3, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,          1'b0, 32'h0020_A423);
    send(4'd4, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,          1'b0, 32'h4020_81B3);
    send(4'd6, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC,  1'b0, 32'hFE20_8EE3);
    in_valid = 1'b0;
    checks++;
    if (count !== 7'd3) begin
      errors++;
      $display("FAIL b2b_count cnt=%0d want 3", count);
    end
    wait_drain("b2b");
  endtask

  task automatic test_uj();
    do_start();
    send(4'd5, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 32'h1234_52B7);
    send(4'd8, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,         1'b1, 32'h0080_00EF);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL last_ready rdy=%b want 0", in_ready);
    end
`ifdef INSTR_ENCODER_NOP_PAD_EN
    for (int a = 2; a < DEPTH; a++) begin
      exp_q.push_back({AW'(a), 32'h0000_0013});
    end
`endif
    wait_done("uj");
    wait_drain("uj");
    checks++;
`ifdef INSTR_ENCODER_NOP_PAD_EN
    if (count !== 7'd64) begin
      errors++;
      $display("FAIL pad_count cnt=%0d want 64", count);
    end
`else
    if (count !== 7'd2) begin
      errors++;
      $display("FAIL uj_count cnt=%0d want 2", count);
    end
`endif
  endtask

  task automatic bad_beat(input string name, input logic [3:0] fmt, input logic [31:0] imm);
    do_start();
    drive(fmt, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, imm, 1'b0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (error !== 1'b1 || in_ready !== 1'b0 || count !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s err=%b rdy=%b cnt=%0d done=%b want 1 0 0 0", name, error, in_ready, count, done);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_errors();
    bad_beat("err_fmt12", 4'd12, 32'd0);
    bad_beat("err_jal_odd", 4'd8, 32'd7);
    bad_beat("err_branch_odd", 4'd6, 32'd3);
    do_start();
    checks++;
    if (error !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_clear err=%b rdy=%b want 0 1", error, in_ready);
    end
  endtask

  task automatic test_full();
    logic [31:0] imm;
    logic [4:0]  rd;
    do_start();
    for (int i = 0; i < DEPTH; i++) begin
      imm = i * 3;
      rd  = 5'(i % 32);
      send(4'd1, 3'b000, 1'b0, rd, 5'd2, 5'd0, imm, 1'b0,
           (imm << 20) + (32'(rd) << 7) + (32'd2 << 15) + 32'h13);
    end
    checks++;
    if (in_ready !== 1'b0 || count !== 7'd64) begin
      errors++;
      $display("FAIL full_state rdy=%b cnt=%0d want 0 64", in_ready, count);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_done("full");
    wait_drain("full");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_uj();
    test_errors();
    test_full();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue pending=%0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart of the core's opcode/control decoder.
- Accepts decoded instruction fields as a stream, one instruction per valid/ready beat.
- Packs each into a 32-bit RV32I word, opcode matching the decoder's supported set.
- Writes the words sequentially into instruction memory through a registered write port. Used for self-test program generation and bench program loading.

Parameters:
- IMEM_DEPTH, 64, number of 32-bit words in instruction memory.
- ADDR_W, $clog2(IMEM_DEPTH), word-address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: clear counters and error, begin load at word 0.
- in_valid  in  1  field beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_fmt  in  4  class: 0 LOAD, 1 OPIMM, 2 AUIPC, 3 STORE, 4 OP, 5 LUI, 6 BRANCH, 7 JALR, 8 JAL, 9-15 illegal.
- in_funct3  in  3  funct3.
- in_f7b5  in  1  instr[30] for OP and OPIMM shifts.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  immediate as a sign-extended byte value. U-type uses in_imm[31:12].
- in_last  in  1  final instruction of program.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written.
- done  out  1  load complete (sticky).
- error  out  1  illegal beat seen (sticky).

Behaviour:
- Reset outputs: all outputs 0; state IDLE.
- FSM states: IDLE, LOAD, PAD, DONE, ERR.
- IDLE: in_ready=0. start -> LOAD, count=0, done=0, error=0.
- LOAD: in_ready=1 when count<IMEM_DEPTH.
- Beat accept: accepted on cycle N when in_valid&&in_ready.
  - imem_we=1 on cycle N+1 only.
  - imem_addr = count value at N; imem_wdata = registered encoding.
  - count increments at N+1.
- Throughput: one beat per cycle, back-to-back.
- Opcodes by class: 0000011, 0010011, 0010111, 0100011, 0110011, 0110111, 1100011, 1100111, 1101111.
- Field placement:
  - rd in [11:7]; rs1 in [19:15]; rs2 in [24:20]; funct3 in [14:12], where the format has them.
  - I: imm[11:0] in [31:20]. OPIMM with funct3 001/101: [31:25]={0,f7b5,00000}, [24:20]=imm[4:0].
  - R: [31:25]={0,f7b5,00000}.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: {imm[12],imm[10:5]}→[31:25], {imm[4:1],imm[11]}→[11:7].
  - U: [31:12]=imm[31:12].
  - J: [31:12]={imm[20],imm[10:1],imm[11],imm[19:12]}.
  - JALR: funct3 forced 000.
- Illegal beats (no write for the failing beat) -> ERR, error=1, in_ready=0:
  - in_fmt 9-15.
  - BRANCH/JAL with in_imm[0]=1.
- ERR exit: only via start or reset.
- Beat with in_last=1: write completes at N+1, then state -> DONE, done=1, in_ready=0.
- Full: the write with count reaching IMEM_DEPTH -> DONE regardless of in_last. Further beats are not accepted.
- start in LOAD/PAD/DONE/ERR: restart at word 0. A write scheduled for that cycle is still issued; the counter then clears.
- Reset mid-load: all state and outputs return to reset values immediately. Memory contents are undefined.

Optional Feature:
- Macro: INSTR_ENCODER_NOP_PAD_EN.
- Defined: after the in_last write, state PAD writes NOP 0x00000013 to each remaining address, one per cycle. Then DONE; done asserts the cycle after the final pad write (count==IMEM_DEPTH). in_ready=0 during PAD.
- Undefined: PAD state absent; in_last goes straight to DONE.

Test Plan:
- Single instruction: start; one beat OPIMM rd=1 rs1=0 f3=000 imm=5 -> cycle N+1: we=1, addr=0, wdata=0x00500093.
- Back-to-back stream, one beat per cycle, no gaps:
  - STORE rs1=1 rs2=2 f3=010 imm=8 -> 0x0020A423.
  - OP rd=3 rs1=1 rs2=2 f7b5=1 -> 0x402081B3.
  - BRANCH rs1=1 rs2=2 f3=000 imm=-4 -> 0xFE208EE3.
  - Required: addrs 0,1,2, count=3.
- U/J types:
  - LUI rd=5 imm=0x12345000 -> 0x123452B7.
  - JAL rd=1 imm=8 with in_last -> 0x008000EF, then done=1.
- Errors, each -> error=1, no write, in_ready=0 until start:
  - in_fmt=12.
  - JAL imm=7.
- Full memory: IMEM_DEPTH beats without in_last -> in_ready drops after the last accept, done=1, count=64.
- With INSTR_ENCODER_NOP_PAD_EN: 2 beats, second with in_last -> addresses 2..63 written 0x00000013, then done=1.
